// File: rtl/uart_cmd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl_pkg
// Shared definitions for the UART command-frame controller and its watchdog.
//   state_e                : one-hot controller states (same style as uart_rx)
//   OPCODE_NOPS_LSB/_W     : location of the operand-count field in the opcode
//   TIMEOUT_TICKS_DEFAULT  : default inter-byte watchdog limit in i_tick units
// -----------------------------------------------------------------------------
package uart_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b001,
        ST_OPERANDS = 3'b010,
        ST_ISSUE    = 3'b100
    } state_e;

    localparam int OPCODE_NOPS_LSB       = 0;
    localparam int OPCODE_NOPS_W         = 2;

    // 128 bit-times at 16x oversampling
    localparam int TIMEOUT_TICKS_DEFAULT = 2048;

endpackage : uart_cmd_ctrl_pkg

// File: rtl/uart_cmd_ctrl_watchdog.sv
// -----------------------------------------------------------------------------
// uart_cmd_watchdog
// Tick counter with synchronous clear, count enable and terminal-count pulse.
// Counts i_tick while enabled; on the tick that finds the counter already at
// TICKS-1 it raises o_expire for that cycle and wraps to zero. A clear in the
// same cycle has priority and suppresses the expiry.
// Ports:
//   clk       in   system clock
//   i_reset   in   asynchronous, active-high reset
//   i_clear   in   synchronous clear (priority over counting)
//   i_enable  in   counting enable
//   i_tick    in   count strobe
//   o_expire  out  combinational terminal-count pulse (registered by the user)
// -----------------------------------------------------------------------------
module uart_cmd_watchdog #(
    parameter int TICKS = 2048
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_tick,
    output logic o_expire
);

    localparam int               CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(TICKS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             expire_s;

    // Next count and terminal-count detection
    always_comb begin
        count_d  = count_q;
        expire_s = 1'b0;
        if (i_clear) begin
            count_d = {CNT_W{1'b0}};
        end else if (i_enable && i_tick) begin
            if (count_q == TERM) begin
                expire_s = 1'b1;
                count_d  = {CNT_W{1'b0}};
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign o_expire = expire_s;

endmodule : uart_cmd_watchdog

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
// Assembles command frames (opcode + 0..3 operand bytes, count = opcode[1:0])
// from the uart_rx byte stream and presents them over valid/ready. A watchdog
// on the baud tick aborts frames that stall between bytes.
// Ports:
//   clk, i_reset          clock, asynchronous active-high reset
//   i_tick                16x baud tick (watchdog time base)
//   i_rx_data, i_rx_done  received byte and its one-cycle strobe
//   o_cmd_opcode          opcode of the presented command
//   o_cmd_operand         operands, little-endian, unused bytes zero
//   o_cmd_nops            operand byte count
//   o_cmd_valid/i_cmd_ready  command handshake; valid held until accepted
//   o_overrun             pulse: byte dropped while a command was pending
//   o_timeout             pulse: partial frame discarded by the watchdog
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int NB_DATA       = 8,
    parameter int NB_OPER       = 32,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_cmd_opcode,
    output logic [NB_OPER-1:0] o_cmd_operand,
    output logic [1:0]         o_cmd_nops,
    output logic               o_cmd_valid,
    input  logic               i_cmd_ready,
    output logic               o_overrun,
    output logic               o_timeout
);

    state_e             state_q,   state_d;
    logic [NB_DATA-1:0] opcode_q,  opcode_d;
    logic [NB_OPER-1:0] operand_q, operand_d;
    logic [1:0]         nops_q,    nops_d;
    logic [1:0]         idx_q,     idx_d;
    logic               valid_q,   valid_d;
    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;

    logic [OPCODE_NOPS_W-1:0] rx_nops_s;
    state_e                   load_state_s;
    logic                     load_valid_s;
    logic                     wd_clear_s;
    logic                     wd_enable_s;
    logic                     wd_expire_s;

    assign rx_nops_s    = i_rx_data[OPCODE_NOPS_LSB +: OPCODE_NOPS_W];
    // Where a freshly loaded opcode sends the FSM: straight to ISSUE when it
    // carries no operands, so valid rises one clock after the opcode byte.
    assign load_state_s = (rx_nops_s == 2'd0) ? ST_ISSUE : ST_OPERANDS;
    assign load_valid_s = (rx_nops_s == 2'd0);

    // The watchdog only runs while collecting operands; any accepted byte, or
    // being anywhere else, restarts it. Clear beats expiry, so a byte landing
    // on the timeout tick is kept.
    assign wd_enable_s = (state_q == ST_OPERANDS);
    assign wd_clear_s  = i_rx_done || (state_q != ST_OPERANDS);

    uart_cmd_watchdog #(
        .TICKS    (TIMEOUT_TICKS)
    ) u_watchdog (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_clear  (wd_clear_s),
        .i_enable (wd_enable_s),
        .i_tick   (i_tick),
        .o_expire (wd_expire_s)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        nops_d    = nops_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_rx_done) begin
                    opcode_d  = i_rx_data;
                    operand_d = {NB_OPER{1'b0}};
                    nops_d    = rx_nops_s;
                    idx_d     = 2'd0;
                    state_d   = load_state_s;
                    valid_d   = load_valid_s;
                end else begin
                    valid_d   = 1'b0;
                end
            end

            ST_OPERANDS: begin
                if (i_rx_done) begin
                    operand_d[int'(idx_q) * NB_DATA +: NB_DATA] = i_rx_data;
                    if (idx_q == (nops_q - 2'd1)) begin
                        state_d = ST_ISSUE;
                        valid_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                    end
                end else if (wd_expire_s) begin
                    // Drop the partial frame entirely so nothing stale leaks
                    // onto the command outputs.
                    state_d   = ST_IDLE;
                    opcode_d  = {NB_DATA{1'b0}};
                    operand_d = {NB_OPER{1'b0}};
                    nops_d    = 2'd0;
                    idx_d     = 2'd0;
                    timeout_d = 1'b1;
                end else begin
                    valid_d   = 1'b0;
                end
            end

            ST_ISSUE: begin
                if (valid_q && i_cmd_ready) begin
                    if (i_rx_done) begin
                        // Accept and start the next frame in the same cycle.
                        opcode_d  = i_rx_data;
                        operand_d = {NB_OPER{1'b0}};
                        nops_d    = rx_nops_s;
                        idx_d     = 2'd0;
                        state_d   = load_state_s;
                        valid_d   = load_valid_s;
                    end else begin
                        state_d   = ST_IDLE;
                        valid_d   = 1'b0;
                    end
                end else if (i_rx_done) begin
                    overrun_d = 1'b1;
                    valid_d   = 1'b1;
                end else begin
                    valid_d   = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                idx_d   = 2'd0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            opcode_q  <= {NB_DATA{1'b0}};
            operand_q <= {NB_OPER{1'b0}};
            nops_q    <= 2'd0;
            idx_q     <= 2'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            nops_q    <= nops_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_cmd_opcode  = opcode_q;
    assign o_cmd_operand = operand_q;
    assign o_cmd_nops    = nops_q;
    assign o_cmd_valid   = valid_q;
    assign o_overrun     = overrun_q;
    assign o_timeout     = timeout_q;

endmodule : uart_cmd_ctrl

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
// Self-checking bench for uart_cmd_ctrl. Expected commands are queued when the
// final byte of a frame is driven; a monitor pops and compares them whenever
// the DUT hands over a command (valid && ready). Inputs change 1 time unit
// after the rising edge, outputs are sampled on the falling edge or right
// after the input update.
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] oper;
        logic [1:0]  nops;
    } cmd_t;

    logic        clk;
    logic        i_reset;
    logic        i_tick;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic [7:0]  o_cmd_opcode;
    logic [31:0] o_cmd_operand;
    logic [1:0]  o_cmd_nops;
    logic        o_cmd_valid;
    logic        i_cmd_ready;
    logic        o_overrun;
    logic        o_timeout;

    int   n_checks = 0;
    int   n_errors = 0;
    int   ovr_cnt  = 0;
    int   to_cnt   = 0;
    int   to_base;
    int   ovr_base;
    cmd_t sb[$];
    cmd_t exp_c;

    uart_cmd_ctrl #(
        .NB_DATA       (8),
        .NB_OPER       (32),
        .TIMEOUT_TICKS (2048)
    ) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_tick        (i_tick),
        .i_rx_data     (i_rx_data),
        .i_rx_done     (i_rx_done),
        .o_cmd_opcode  (o_cmd_opcode),
        .o_cmd_operand (o_cmd_operand),
        .o_cmd_nops    (o_cmd_nops),
        .o_cmd_valid   (o_cmd_valid),
        .i_cmd_ready   (i_cmd_ready),
        .o_overrun     (o_overrun),
        .o_timeout     (o_timeout)
    );

    // 100 MHz-style clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        step(1);
        i_rx_done = 1'b0;
    endtask

    task automatic push(input logic [7:0] op, input logic [31:0] oper, input logic [1:0] nops);
        cmd_t c;
        c.op   = op;
        c.oper = oper;
        c.nops = nops;
        sb.push_back(c);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"},   o_cmd_valid,   64'd0);
        check_eq({tag, "_opcode"},  o_cmd_opcode,  64'd0);
        check_eq({tag, "_operand"}, o_cmd_operand, 64'd0);
        check_eq({tag, "_nops"},    o_cmd_nops,    64'd0);
        check_eq({tag, "_overrun"}, o_overrun,     64'd0);
        check_eq({tag, "_timeout"}, o_timeout,     64'd0);
    endtask

    // Monitor: count pulses and compare every handed-over command
    initial begin
        forever begin
            @(negedge clk);
            if (!i_reset) begin
                if (o_overrun) ovr_cnt++;
                if (o_timeout) to_cnt++;
                if (o_cmd_valid && i_cmd_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_unexpected_cmd", 64'd1, 64'd0);
                    end else begin
                        exp_c = sb.pop_front();
                        check_eq("cmd_opcode",  o_cmd_opcode,  exp_c.op);
                        check_eq("cmd_operand", o_cmd_operand, exp_c.oper);
                        check_eq("cmd_nops",    o_cmd_nops,    exp_c.nops);
                    end
                end
            end
        end
    end

    initial begin
        i_reset     = 1'b1;
        i_tick      = 1'b0;
        i_rx_data   = 8'h00;
        i_rx_done   = 1'b0;
        i_cmd_ready = 1'b0;
        step(3);
        check_all_zero("reset");
        i_reset = 1'b0;
        step(2);

        // nops=0: valid one clock after the opcode, exactly one cycle long
        i_cmd_ready = 1'b1;
        push(8'h00, 32'h0, 2'd0);
        send(8'h00);
        check_eq("t1_latency", o_cmd_valid, 64'd1);
        step(1);
        check_eq("t1_one_cycle", o_cmd_valid, 64'd0);

        // Three operand bytes, little-endian
        push(8'h03, 32'h00CCBBAA, 2'd3);
        send(8'h03);
        send(8'hAA);
        send(8'hBB);
        check_eq("t2_not_early", o_cmd_valid, 64'd0);
        send(8'hCC);
        check_eq("t2_valid", o_cmd_valid, 64'd1);
        check_eq("t2_operand", o_cmd_operand, 64'h00CCBBAA);
        step(1);
        check_eq("t2_drop", o_cmd_valid, 64'd0);

        // Stalled frame aborted by the watchdog, then a clean frame
        to_base = to_cnt;
        send(8'h02);
        send(8'h11);
        i_tick = 1'b1;
        step(2046);
        check_eq("t3_no_early_timeout", to_cnt, to_base);
        check_eq("t3_no_valid", o_cmd_valid, 64'd0);
        step(2);
        i_tick = 1'b0;
        step(2);
        check_eq("t3_timeout_once", to_cnt, to_base + 1);
        check_eq("t3_no_valid_after", o_cmd_valid, 64'd0);
        push(8'h01, 32'h00000022, 2'd1);
        send(8'h01);
        send(8'h22);
        check_eq("t3_next_valid", o_cmd_valid, 64'd1);
        step(1);

        // Byte arriving on the would-be timeout tick is kept
        to_base = to_cnt;
        push(8'h02, 32'h00004433, 2'd2);
        send(8'h02);
        send(8'h33);
        i_tick = 1'b1;
        step(2047);
        i_rx_data = 8'h44;
        i_rx_done = 1'b1;
        step(1);
        i_rx_done = 1'b0;
        i_tick    = 1'b0;
        check_eq("t3b_byte_wins_valid", o_cmd_valid, 64'd1);
        step(2);
        check_eq("t3b_no_timeout", to_cnt, to_base);

        // Overrun while a command waits for ready
        i_cmd_ready = 1'b0;
        ovr_base    = ovr_cnt;
        push(8'h01, 32'h00000055, 2'd1);
        send(8'h01);
        send(8'h55);
        check_eq("t4_valid", o_cmd_valid, 64'd1);
        step(2);
        check_eq("t4_held", o_cmd_valid, 64'd1);
        send(8'h77);
        check_eq("t4_overrun_pulse", o_overrun, 64'd1);
        step(1);
        check_eq("t4_overrun_end", o_overrun, 64'd0);
        check_eq("t4_stable_opcode", o_cmd_opcode, 64'h01);
        check_eq("t4_stable_operand", o_cmd_operand, 64'h55);
        check_eq("t4_stable_nops", o_cmd_nops, 64'd1);
        i_cmd_ready = 1'b1;
        step(1);
        check_eq("t4_accepted", o_cmd_valid, 64'd0);
        check_eq("t4_overrun_count", ovr_cnt, ovr_base + 1);

        // Accept and new opcode in the same cycle: back-to-back, no overrun
        i_cmd_ready = 1'b0;
        push(8'h00, 32'h0, 2'd0);
        send(8'h00);
        check_eq("t5_first_valid", o_cmd_valid, 64'd1);
        push(8'h00, 32'h0, 2'd0);
        i_cmd_ready = 1'b1;
        send(8'h00);
        check_eq("t5_second_valid", o_cmd_valid, 64'd1);
        check_eq("t5_no_overrun", o_overrun, 64'd0);
        step(1);
        check_eq("t5_drop", o_cmd_valid, 64'd0);

        // Asynchronous reset mid-frame, then a clean frame
        send(8'h03);
        send(8'h01);
        i_reset = 1'b1;
        #1;
        check_all_zero("t6_reset");
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        step(1);
        push(8'h00, 32'h0, 2'd0);
        send(8'h00);
        check_eq("t6_valid", o_cmd_valid, 64'd1);
        check_eq("t6_clean_operand", o_cmd_operand, 64'd0);
        step(2);

        check_eq("sb_empty", sb.size(), 64'd0);
        check_eq("total_timeouts", to_cnt, 64'd1);
        check_eq("total_overruns", ovr_cnt, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_cmd_ctrl

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command-frame controller sitting directly behind uart_rx. It consumes the received-byte stream (byte bus plus one-cycle done pulse) and assembles command frames: one opcode byte followed by 0-3 operand bytes. A watchdog runs on the baud tick and aborts frames that stall between bytes. It presents each complete command to the downstream datapath over a valid/ready handshake and flags overruns and timeouts.

Parameters:
NB_DATA, 8, width of a received byte and of the opcode field
NB_OPER, 32, operand output width; must be 4*NB_DATA
TIMEOUT_TICKS, 2048, i_tick count allowed between bytes of one frame before abort (128 bit-times at 16x oversampling)

Ports:
clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_tick  in  1  baud oversampling tick (16x), same source feeding uart_rx
i_rx_data  in  NB_DATA  received byte from uart_rx
i_rx_done  in  1  one-cycle pulse; i_rx_data is valid in that cycle
o_cmd_opcode  out  NB_DATA  opcode of the presented command
o_cmd_operand  out  NB_OPER  operands, little-endian: first operand byte in [7:0]; unused bytes are 0
o_cmd_nops  out  2  number of operand bytes in the presented command
o_cmd_valid  out  1  command available; held until accepted
i_cmd_ready  in  1  downstream accepts the command when asserted together with o_cmd_valid
o_overrun  out  1  one-cycle pulse: a byte was dropped
o_timeout  out  1  one-cycle pulse: partial frame aborted by watchdog

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; operand register 0; byte counter 0; watchdog 0.
- Opcode decode: operand count = opcode[1:0] (0..3).
- IDLE:
  - On i_rx_done, latch opcode, clear operand register, capture nops, clear watchdog.
  - If nops==0, go to ISSUE; else go to OPERANDS with byte index 0.
- OPERANDS:
  - On i_rx_done, write the byte into operand slot [index].
  - If index==nops-1, go to ISSUE; else increment index.
  - Watchdog clears on every accepted byte and increments on each i_tick otherwise.
  - Watchdog reaching TIMEOUT_TICKS-1 on an i_tick: go to IDLE, pulse o_timeout, discard the partial frame.
  - If i_rx_done and the timeout tick coincide, the byte wins: it is accepted, the watchdog clears, and there is no timeout.
- ISSUE:
  - o_cmd_valid=1; opcode, operand and nops stay stable while valid and not ready.
  - The watchdog does not run.
  - valid&&ready: go to IDLE and drop valid in the next cycle.
  - valid&&ready with i_rx_done in the same cycle: the byte is taken as the next opcode using IDLE rules, so back-to-back frames are lossless.
  - i_rx_done without ready: byte dropped, o_overrun pulses 1 cycle, state unchanged.
- Latency: o_cmd_valid rises 1 clk after the i_rx_done of the final byte (registered). For nops==0, that is 1 clk after the opcode byte.
- i_rx_done is treated as a strict pulse. A pulse held for N cycles counts as N bytes; this is not guarded.
- Illegal or unused state encodings return to IDLE.
- Output and state registers are clocked; next-state logic is combinational.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=3'b001, OPERANDS=3'b010, ISSUE=3'b100 (one-hot, matching the rx convention);
  - OPCODE_NOPS_LSB=0 and OPCODE_NOPS_W=2;
  - default TIMEOUT_TICKS.
- One natural sub-module: uart_cmd_watchdog, a tick counter with clear, enable and terminal-count pulse. It is reusable by a future TX scheduler.

Test Plan:
- Opcode 8'h00 (nops=0) -> o_cmd_valid one clk after done; opcode=8'h00, operand=32'h0, nops=0; ready held high, so valid lasts exactly 1 cycle.
- Bytes 8'h03,8'hAA,8'hBB,8'hCC with ready high -> single command: opcode=8'h03, operand=32'h00CCBBAA, nops=3.
- 8'h02,8'h11, then no byte for 2048 ticks -> o_timeout pulses once, no valid. The next byte 8'h01,8'h22 -> command with operand 32'h00000022.
- Frame 8'h01,8'h55 with ready low; send byte 8'h77 -> o_overrun pulses and the command stays opcode=8'h01, operand=32'h55. Raise ready -> accepted, back to IDLE.
- ready asserted in the same cycle as i_rx_done of 8'h00 -> first command accepted, second command (opcode 8'h00) valid the next cycle, no overrun.
- Assert i_reset mid-frame after 8'h03,8'h01 -> all outputs 0 immediately. The next frame 8'h00 decodes cleanly, with no leftover operand bytes.
